rf_access_ctrl: RTL
===================

Name: rf_access_ctrl

Overview:
- Scheduler for the 32x32 register file (rf_32) in the MIPS pipeline.
- Admits decode-stage issue requests only when the source and destination registers are hazard-free, using a per-register busy scoreboard.
- Drives rf_32's read port and shares its single write port between two writeback requesters (ALU, MEM) with round-robin arbitration.
- Sits between decode/writeback logic and rf_32; all rf_32 control/address/data inputs come from this block.

Parameters:
- REG_SIZE, 32, data width of a register.
- REGFILE_SIZE, 32, number of registers.
- INDEX_SIZE, 5, register address width; must equal log2(REGFILE_SIZE).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- iss_valid  in  1  decode has an instruction to issue.
- iss_rs  in  INDEX_SIZE  source register s.
- iss_rt  in  INDEX_SIZE  source register t.
- iss_rd  in  INDEX_SIZE  destination register.
- iss_wr  in  1  instruction writes iss_rd.
- iss_ready  out  1  issue accepted this cycle (combinational).
- opnd_valid  out  1  rf_32 outA/outB hold this issue's operands (registered).
- alu_wb_valid  in  1  ALU writeback request.
- alu_wb_addr  in  INDEX_SIZE  ALU writeback destination.
- alu_wb_data  in  REG_SIZE  ALU writeback data.
- alu_wb_ready  out  1  ALU writeback granted (combinational).
- mem_wb_valid  in  1  MEM writeback request.
- mem_wb_addr  in  INDEX_SIZE  MEM writeback destination.
- mem_wb_data  in  REG_SIZE  MEM writeback data.
- mem_wb_ready  out  1  MEM writeback granted (combinational).
- rf_read_enabled  out  1  to rf_32 read_enabled.
- rf_read_addr_s  out  INDEX_SIZE  to rf_32 read_addr_s.
- rf_read_addr_t  out  INDEX_SIZE  to rf_32 read_addr_t.
- rf_write_enabled  out  1  to rf_32 write_enabled.
- rf_write_addr  out  INDEX_SIZE  to rf_32 write_addr.
- rf_write_data  out  REG_SIZE  to rf_32 write_data.
- wb_err  out  1  sticky: a writeback targeted a non-busy nonzero register.
- stall_count  out  32  saturating count of cycles with iss_valid=1 and iss_ready=0.

Behaviour:
- Reset:
  - busy[] all 0.
  - RR pointer = ALU.
  - opnd_valid=0, wb_err=0, stall_count=0.
  - Combinational outputs follow their inputs during and after reset, except: iss_ready=0, both wb_ready=0 and rf_write_enabled=0 while reset=1.
- Scoreboard:
  - busy[0] is constantly 0.
  - busy[x] is set at the posedge where an issue fires with iss_wr=1 and iss_rd=x≠0.
  - busy[x] is cleared at the posedge where a writeback to x is granted.
- Issue rule: iss_ready = iss_valid & !busy[iss_rs] & !busy[iss_rt] & !(iss_wr & busy[iss_rd]).
  - Stalls on RAW (busy source) and WAW (busy destination).
  - Uses register-state busy only; a grant clearing x in the same cycle does not unblock x until the next cycle.
  - rf_32 would return the old value on a same-edge read, so this rule is mandatory.
- Read port:
  - rf_read_enabled = iss_ready.
  - rf_read_addr_s/t = iss_rs/iss_rt (combinational passthrough).
  - opnd_valid <= iss_ready, so the operands appear on rf_32 outA/outB one cycle after the issue fires (latency 1).
- Write arbitration:
  - At most one grant per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester named by the RR pointer wins; the pointer then moves to the other requester.
  - The pointer updates only on a contended grant.
  - The write commits in rf_32 at the same posedge as the handshake.
  - rf_write_* are muxed combinationally from the granted requester.
- Write to register 0: the request is granted, but rf_write_enabled=0, busy is unaffected and wb_err is not set.
- Writeback to a nonzero x with busy[x]=0: the request is still granted and written, and wb_err <= 1 (sticky until reset).
- Issue and grant in the same cycle are independent: the read and the write both happen. Issue may claim a register y while a grant clears a different register x.
- stall_count increments when iss_valid & !iss_ready and saturates at 32'hFFFF_FFFF.
- Reset mid-operation: busy[] is cleared and the RR pointer returns to ALU. In-flight writebacks after reset are legal; they will set wb_err.

Decomposition:
- Shared package holds: REG_SIZE, REGFILE_SIZE, INDEX_SIZE, ZERO, and requester encoding (WB_ALU=0, WB_MEM=1).
- One sub-module: rf_wb_rr_arbiter, a 2-way round-robin arbiter (valids in, one-hot grant out, pointer state).
- The scoreboard and issue logic stay in the top-level module.

Test Plan:
- Reset, then issue rs=1, rt=2, rd=3, wr=1 → iss_ready=1, rf_read_enabled=1 with addrs 1/2, opnd_valid=1 next cycle, busy[3]=1.
- With busy[3] set, issue rs=3 → iss_ready=0 and stall_count increments. ALU wb addr=3, data=32'hDEAD_BEEF granted → issue accepted the following cycle, and outA=32'hDEAD_BEEF one cycle later.
- Claim r5 and r6, then ALU(5) and MEM(6) valid together for two cycles → ALU granted first, MEM second; each rf_write_* matches its source.
- ALU wb addr=0 → alu_wb_ready=1, rf_write_enabled=0, wb_err stays 0. MEM wb addr=9 with r9 not busy → granted and written, wb_err=1 and stays 1.
- Issue with rd=7 while busy[7]=1 (WAW) → stall. Assert reset mid-stall → busy cleared, iss_ready=1 in the cycle after reset deasserts.
- Hold iss_valid with a permanently busy source for 5 cycles → stall_count=5. Preload the counter near saturation via a long stall → value holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/rf_access_ctrl_pkg.sv
// Shared sizes and writeback requester encoding for the register-file access controller.
package rf_access_ctrl_pkg;

  localparam int REG_SIZE     = 32;
  localparam int REGFILE_SIZE = 32;
  localparam int INDEX_SIZE   = 5;

  localparam logic [INDEX_SIZE-1:0] ZERO = '0;

  // Writeback requester identity; also the round-robin pointer encoding.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_req_e;

endpackage

// File: rtl/rf_wb_rr_arbiter.sv
// Two-way round-robin arbiter for the single rf_32 write port.
// req_valid/grant bit 0 = ALU, bit 1 = MEM. The pointer only moves on a
// contended grant, handing priority to the requester that just lost.
module rf_wb_rr_arbiter
  import rf_access_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] grant
);

  wb_req_e ptr_q;
  wb_req_e ptr_d;

  // Grant selection and next pointer; no grants while reset is held.
  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    if (!reset) begin
      case (req_valid)
        2'b01: grant = 2'b01;
        2'b10: grant = 2'b10;
        2'b11: begin
          if (ptr_q == WB_ALU) begin
            grant = 2'b01;
            ptr_d = WB_MEM;
          end else begin
            grant = 2'b10;
            ptr_d = WB_ALU;
          end
        end
        default: grant = 2'b00;
      endcase
    end
  end

  // Pointer register; reset gives ALU first priority.
  always_ff @(posedge clock) begin
    if (reset) ptr_q <= WB_ALU;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// Issue/writeback scheduler in front of rf_32: per-register busy scoreboard
// gates decode issue (RAW/WAW), drives the read port, and arbitrates the
// single write port between ALU and MEM writeback.
module rf_access_ctrl
  import rf_access_ctrl_pkg::*;
#(
  parameter int REG_SIZE     = rf_access_ctrl_pkg::REG_SIZE,
  parameter int REGFILE_SIZE = rf_access_ctrl_pkg::REGFILE_SIZE,
  parameter int INDEX_SIZE   = rf_access_ctrl_pkg::INDEX_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic [INDEX_SIZE-1:0] iss_rs,
  input  logic [INDEX_SIZE-1:0] iss_rt,
  input  logic [INDEX_SIZE-1:0] iss_rd,
  input  logic                  iss_wr,
  output logic                  iss_ready,
  output logic                  opnd_valid,
  input  logic                  alu_wb_valid,
  input  logic [INDEX_SIZE-1:0] alu_wb_addr,
  input  logic [REG_SIZE-1:0]   alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  mem_wb_valid,
  input  logic [INDEX_SIZE-1:0] mem_wb_addr,
  input  logic [REG_SIZE-1:0]   mem_wb_data,
  output logic                  mem_wb_ready,
  output logic                  rf_read_enabled,
  output logic [INDEX_SIZE-1:0] rf_read_addr_s,
  output logic [INDEX_SIZE-1:0] rf_read_addr_t,
  output logic                  rf_write_enabled,
  output logic [INDEX_SIZE-1:0] rf_write_addr,
  output logic [REG_SIZE-1:0]   rf_write_data,
  output logic                  wb_err,
  output logic [31:0]           stall_count
);

  logic [REGFILE_SIZE-1:0] busy_q, busy_d;
  logic                    opnd_valid_q, opnd_valid_d;
  logic                    wb_err_q, wb_err_d;
  logic [31:0]             stall_count_q, stall_count_d;

  logic [1:0]              wb_grant;
  logic                    wb_fire;
  logic [INDEX_SIZE-1:0]   wb_addr;
  logic [REG_SIZE-1:0]     wb_data;

  rf_wb_rr_arbiter u_arb (
    .clock     (clock),
    .reset     (reset),
    .req_valid ({mem_wb_valid, alu_wb_valid}),
    .grant     (wb_grant)
  );

  // Issue check uses registered busy only: a same-edge write would not be
  // visible to the rf_32 read, so a clearing grant cannot unblock this cycle.
  always_comb begin
    iss_ready = 1'b0;
    if (!reset && iss_valid) begin
      iss_ready = !busy_q[iss_rs] && !busy_q[iss_rt] && !(iss_wr && busy_q[iss_rd]);
    end
  end

  // Write-port mux from the granted requester; register 0 writes are swallowed.
  always_comb begin
    wb_fire = wb_grant[0] | wb_grant[1];
    wb_addr = alu_wb_addr;
    wb_data = alu_wb_data;
    if (wb_grant[1]) begin
      wb_addr = mem_wb_addr;
      wb_data = mem_wb_data;
    end
  end

  assign alu_wb_ready     = wb_grant[0];
  assign mem_wb_ready     = wb_grant[1];
  assign rf_write_enabled = wb_fire && (wb_addr != ZERO);
  assign rf_write_addr    = wb_addr;
  assign rf_write_data    = wb_data;

  assign rf_read_enabled  = iss_ready;
  assign rf_read_addr_s   = iss_rs;
  assign rf_read_addr_t   = iss_rt;

  assign opnd_valid       = opnd_valid_q;
  assign wb_err           = wb_err_q;
  assign stall_count      = stall_count_q;

  // Next-state: scoreboard clear on grant then set on issue, error flag, stall counter.
  always_comb begin
    busy_d        = busy_q;
    opnd_valid_d  = iss_ready;
    wb_err_d      = wb_err_q;
    stall_count_d = stall_count_q;
    if (wb_fire && (wb_addr != ZERO)) begin
      busy_d[wb_addr] = 1'b0;
      if (!busy_q[wb_addr]) wb_err_d = 1'b1;
    end
    if (iss_ready && iss_wr && (iss_rd != ZERO)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (iss_valid && !iss_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q        <= '0;
      opnd_valid_q  <= 1'b0;
      wb_err_q      <= 1'b0;
      stall_count_q <= '0;
    end else begin
      busy_q        <= busy_d;
      opnd_valid_q  <= opnd_valid_d;
      wb_err_q      <= wb_err_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule
